imem_responder: RTL and testbench



---
 rtl/imem_responder_pkg.sv | 17 +
 rtl/imem_array.sv | 32 +++
 rtl/imem_responder.sv | 110 +++++++++++
 tb/tb_imem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared state encoding and constants for the instruction-memory responder
package imem_responder_pkg;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10,
      ST_ERR  = 2'b11
   } state_t;

   // Default access latency and the counter width that covers LATENCY 1..7
   localparam int DEFAULT_LATENCY = 2;
   localparam int CNT_W           = 3;
   localparam int WORD_W          = 16;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - 2^AW x 16 storage, one synchronous write port and one registered read port
module imem_array
   import imem_responder_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [0:(2**AW)-1];

   // Load-port write; contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // One-cycle read, output held until the next read
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - multi-cycle instruction-memory responder with load port and misalignment reporting
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int AW      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic [15:0]       addr,
   input  logic              halt,
   input  logic              wr,
   input  logic [15:0]       wr_addr,
   input  logic [15:0]       wr_data,
   output logic [WORD_W-1:0] data_out,
   output logic              done,
   output logic              stall,
   output logic              err
);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [AW:0]       addr_q;
   logic              open_slot;
   logic              arr_we;
   logic              arr_re;
   logic [WORD_W-1:0] arr_rdata;
   logic              unused_addr_bits;

   // Upper address bits alias onto the array; byte bit 0 of the load address is don't-care
   assign unused_addr_bits = ^{addr[15:AW+1], wr_addr[15:AW+1], wr_addr[0]};

   // IDLE and DONE are the only states where a new operation may start
   assign open_slot = (state == ST_IDLE) || (state == ST_DONE);
   assign arr_we    = open_slot && wr && !rd && !halt;
   assign arr_re    = (state == ST_BUSY) && (cnt == '0);

   imem_array #(
      .AW (AW)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (wr_addr[AW:1]),
      .wdata (wr_data),
      .re    (arr_re),
      .raddr (addr_q[AW:1]),
      .rdata (arr_rdata)
   );

   // The read word is only presented during the DONE cycle; ERR forces zero
   assign data_out = (state == ST_DONE) ? arr_rdata : '0;

   // Request FSM with latency counter and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         addr_q <= '0;
         done   <= 1'b0;
         stall  <= 1'b0;
         err    <= 1'b0;
      end else begin
         done  <= 1'b0;
         stall <= 1'b0;
         err   <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               if (!halt && rd && wr) begin
                  err <= 1'b1;
               end else if (!halt && rd) begin
                  addr_q <= addr[AW:0];
                  cnt    <= CNT_W'(LATENCY - 1);
                  if (addr[0]) begin
                     state <= ST_ERR;
                     err   <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_BUSY;
                     stall <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               if (wr) begin
                  err <= 1'b1;
               end
               if (cnt == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  cnt   <= cnt - 1'b1;
                  stall <= 1'b1;
               end
            end
            ST_ERR: begin
               if (wr) begin
                  err <= 1'b1;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd;
   logic [15:0] addr;
   logic        halt;
   logic        wr;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic [15:0] data_out;
   logic        done;
   logic        stall;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   imem_responder #(
      .LATENCY (2),
      .AW      (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd       (rd),
      .addr     (addr),
      .halt     (halt),
      .wr       (wr),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .data_out (data_out),
      .done     (done),
      .stall    (stall),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare {done, stall, err, data_out} for the current cycle
   task automatic expect_cyc(input string tag, input logic d, input logic s, input logic e,
                             input logic [15:0] dat);
      chk(tag, {13'd0, done, stall, err, data_out}, {13'd0, d, s, e, dat});
   endtask

   initial begin
      rst = 1'b1; rd = 1'b0; addr = '0; halt = 1'b0;
      wr = 1'b0; wr_addr = '0; wr_data = '0;
      tick();
      tick();
      expect_cyc("reset", 0, 0, 0, 16'h0000);
      rst = 1'b0;

      // Load 0x0010 <- 0x1234, 0x0012 <- 0xABCD
      wr = 1'b1; wr_addr = 16'h0010; wr_data = 16'h1234;
      tick();
      expect_cyc("load0", 0, 0, 0, 16'h0000);
      wr_addr = 16'h0012; wr_data = 16'hABCD;
      tick();
      wr = 1'b0;

      // Single read, LATENCY=2
      rd = 1'b1; addr = 16'h0010;
      tick();
      rd = 1'b0;
      expect_cyc("rd1_c1", 0, 1, 0, 16'h0000);
      tick();
      expect_cyc("rd1_c2", 0, 1, 0, 16'h0000);
      tick();
      expect_cyc("rd1_c3", 1, 0, 0, 16'h1234);
      tick();
      expect_cyc("rd1_idle", 0, 0, 0, 16'h0000);

      // Back-to-back: second read accepted on the edge leaving DONE
      rd = 1'b1; addr = 16'h0010;
      tick();
      expect_cyc("b2b_c1", 0, 1, 0, 16'h0000);
      addr = 16'h0012;
      tick();
      expect_cyc("b2b_c2", 0, 1, 0, 16'h0000);
      tick();
      expect_cyc("b2b_c3", 1, 0, 0, 16'h1234);
      tick();
      rd = 1'b0;
      expect_cyc("b2b_c4", 0, 1, 0, 16'h0000);
      tick();
      expect_cyc("b2b_c5", 0, 1, 0, 16'h0000);
      tick();
      expect_cyc("b2b_c6", 1, 0, 0, 16'hABCD);
      tick();
      expect_cyc("b2b_idle", 0, 0, 0, 16'h0000);

      // Misaligned read
      rd = 1'b1; addr = 16'h0011;
      tick();
      rd = 1'b0;
      expect_cyc("mis_c1", 1, 0, 1, 16'h0000);
      tick();
      expect_cyc("mis_c2", 0, 0, 0, 16'h0000);

      // Write during BUSY is dropped with err
      rd = 1'b1; addr = 16'h0010;
      tick();
      rd = 1'b0;
      wr = 1'b1; wr_addr = 16'h0010; wr_data = 16'hDEAD;
      tick();
      wr = 1'b0;
      expect_cyc("wrbusy_c2", 0, 1, 1, 16'h0000);
      tick();
      expect_cyc("wrbusy_c3", 1, 0, 0, 16'h1234);
      rd = 1'b1; addr = 16'h0010;
      tick();
      rd = 1'b0;
      tick();
      tick();
      expect_cyc("wrbusy_reread", 1, 0, 0, 16'h1234);

      // rd and wr together: neither performed, one err pulse
      rd = 1'b1; wr = 1'b1; addr = 16'h0010; wr_addr = 16'h0010; wr_data = 16'h5555;
      tick();
      rd = 1'b0; wr = 1'b0;
      expect_cyc("rdwr_c1", 0, 0, 1, 16'h0000);
      tick();
      expect_cyc("rdwr_c2", 0, 0, 0, 16'h0000);

      // Aliased address 0x0210 maps to the same word as 0x0010
      rd = 1'b1; addr = 16'h0210;
      tick();
      rd = 1'b0;
      tick();
      tick();
      expect_cyc("alias", 1, 0, 0, 16'h1234);
      tick();

      // halt holds off acceptance
      halt = 1'b1; rd = 1'b1; addr = 16'h0012;
      tick();
      expect_cyc("halt_c1", 0, 0, 0, 16'h0000);
      tick();
      expect_cyc("halt_c2", 0, 0, 0, 16'h0000);
      tick();
      expect_cyc("halt_c3", 0, 0, 0, 16'h0000);
      halt = 1'b0;
      tick();
      rd = 1'b0;
      expect_cyc("halt_rel_c1", 0, 1, 0, 16'h0000);
      tick();
      expect_cyc("halt_rel_c2", 0, 1, 0, 16'h0000);
      tick();
      expect_cyc("halt_rel_c3", 1, 0, 0, 16'hABCD);
      tick();

      // Reset one cycle into BUSY abandons the read
      rd = 1'b1; addr = 16'h0012;
      tick();
      rd = 1'b0;
      expect_cyc("rstmid_busy", 0, 1, 0, 16'h0000);
      rst = 1'b1;
      tick();
      expect_cyc("rstmid_c1", 0, 0, 0, 16'h0000);
      rst = 1'b0;
      tick();
      expect_cyc("rstmid_c2", 0, 0, 0, 16'h0000);
      tick();
      expect_cyc("rstmid_c3", 0, 0, 0, 16'h0000);

      // Array contents survive reset
      rd = 1'b1; addr = 16'h0012;
      tick();
      rd = 1'b0;
      tick();
      tick();
      expect_cyc("post_rst_read", 1, 0, 0, 16'hABCD);
      tick();
      expect_cyc("final_idle", 0, 0, 0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
